// File: rtl/hbridge_deadtime_if.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_deadtime_if
// Description : Signal bundle between the microstepper phase outputs and
//               the dead-time inserter / gate pins for one coil H-bridge.
//               master = request side (phase generator / bench),
//               slave  = hbridge_deadtime.
// Signals     : enable, deadtime[DT_W], req_high_1/req_low_1,
//               req_high_2/req_low_2, fault_clear   (master -> slave)
//               high_1, low_1, high_2, low_2, fault, busy (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface hbridge_deadtime_if #(
    parameter int DT_W = 8
);
    logic            enable;
    logic [DT_W-1:0] deadtime;
    logic            req_high_1;
    logic            req_low_1;
    logic            req_high_2;
    logic            req_low_2;
    logic            fault_clear;
    logic            high_1;
    logic            low_1;
    logic            high_2;
    logic            low_2;
    logic            fault;
    logic            busy;

    modport master (
        output enable, deadtime, req_high_1, req_low_1,
               req_high_2, req_low_2, fault_clear,
        input  high_1, low_1, high_2, low_2, fault, busy
    );

    modport slave (
        input  enable, deadtime, req_high_1, req_low_1,
               req_high_2, req_low_2, fault_clear,
        output high_1, low_1, high_2, low_2, fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/hbridge_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_deadtime
// Description : Break-before-make dead-time inserter and shoot-through guard
//               for one stepper coil H-bridge (two legs). Each leg runs an
//               OFF / DRV_H / DRV_L FSM with a dead-time down-counter; a leg
//               never drives high and low together and every turn-off is
//               followed by deadtime+1 clocks with both switches open.
// Ports       : clk     - system clock
//               resetn  - asynchronous active-low reset
//               bus     - hbridge_deadtime_if.slave (requests, enable,
//                         deadtime, fault_clear in; gates, fault, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module hbridge_deadtime #(
    parameter int DT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    hbridge_deadtime_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRV_H = 2'd1,
        ST_DRV_L = 2'd2
    } leg_state_t;

    logic [1:0] w_req_h;
    logic [1:0] w_req_l;
    logic [1:0] w_illegal;
    logic       w_any_illegal;
    logic       w_hold;
    logic       r_fault;
    logic       w_fault_next;
    logic [1:0] w_drv_h;
    logic [1:0] w_drv_l;
    logic [1:0] w_cnt_nz;

    assign w_req_h       = {bus.req_high_2, bus.req_high_1};
    assign w_req_l       = {bus.req_low_2,  bus.req_low_1};
    assign w_illegal     = w_req_h & w_req_l;
    assign w_any_illegal = |w_illegal;

    // Both legs are parked whenever a shoot-through request is seen this
    // edge, the sticky fault is still set, or the driver is disabled.
    assign w_hold = w_any_illegal | r_fault | ~bus.enable;

    // An ILLEGAL request outranks a simultaneous clear pulse.
    always_comb begin
        w_fault_next = r_fault;
        if (w_any_illegal) begin
            w_fault_next = 1'b1;
        end else if (bus.fault_clear) begin
            w_fault_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_next;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_leg
        leg_state_t      r_state;
        leg_state_t      w_state_next;
        logic [DT_W-1:0] r_dcnt;
        logic [DT_W-1:0] w_dcnt_next;
        logic [DT_W-1:0] w_dcnt_dec;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_state <= ST_OFF;
                r_dcnt  <= '0;
            end else begin
                r_state <= w_state_next;
                r_dcnt  <= w_dcnt_next;
            end
        end

        // Saturating decrement: the counter idles at zero.
        assign w_dcnt_dec = (r_dcnt != '0) ? (r_dcnt - DT_W'(1)) : '0;

        always_comb begin
            w_state_next = r_state;
            w_dcnt_next  = r_dcnt;
            if (w_hold) begin
                w_state_next = ST_OFF;
                // Only a leg that was actually driving owes a dead time;
                // a leg already off keeps draining its count.
                if (r_state != ST_OFF) begin
                    w_dcnt_next = bus.deadtime;
                end else begin
                    w_dcnt_next = w_dcnt_dec;
                end
            end else begin
                case (r_state)
                    ST_DRV_H: begin
                        if (!(w_req_h[g] && !w_req_l[g])) begin
                            w_state_next = ST_OFF;
                            w_dcnt_next  = bus.deadtime;
                        end
                    end
                    ST_DRV_L: begin
                        if (!(w_req_l[g] && !w_req_h[g])) begin
                            w_state_next = ST_OFF;
                            w_dcnt_next  = bus.deadtime;
                        end
                    end
                    default: begin
                        // Request changes while counting do not restart the
                        // count; whatever is requested when it hits zero wins.
                        // ILLEGAL never reaches here because it forces hold.
                        w_state_next = ST_OFF;
                        if (r_dcnt != '0) begin
                            w_dcnt_next = w_dcnt_dec;
                        end else if (w_req_h[g]) begin
                            w_state_next = ST_DRV_H;
                        end else if (w_req_l[g]) begin
                            w_state_next = ST_DRV_L;
                        end
                    end
                endcase
            end
        end

        assign w_drv_h[g]  = (r_state == ST_DRV_H);
        assign w_drv_l[g]  = (r_state == ST_DRV_L);
        assign w_cnt_nz[g] = (r_dcnt != '0);
    end

    assign bus.high_1 = w_drv_h[0];
    assign bus.low_1  = w_drv_l[0];
    assign bus.high_2 = w_drv_h[1];
    assign bus.low_2  = w_drv_l[1];
    assign bus.fault  = r_fault;
    assign bus.busy   = |w_cnt_nz;

endmodule
`default_nettype wire
